uart_tx_fifo: RTL and testbench

- Byte buffer and launch sequencer directly upstream of the UART transmitter.
- Accepts bytes from the host side through a valid/ready push interface and stores them in a circular FIFO.
- Hands bytes one at a time to the transmitter with a one-cycle write-enable pulse, then waits for the transmitter's done pulse before launching the next byte.
- Includes a watchdog that recovers the sequencer if the done pulse never arrives.

---
 rtl/uart_tx_fifo.sv | 137 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch sequencer feeding a UART transmitter.
// Bytes are pushed on a valid/ready interface, stored in a circular buffer, and launched one at a
// time with a single-cycle write-enable. The next byte waits for the transmitter's done pulse.
// A watchdog returns the sequencer to idle if that pulse never arrives.
module uart_tx_fifo #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              tx_wr_en,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  output logic              tx_busy,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              tx_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LVL_W = ADDR_W + 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic              tx_err_q, tx_err_d;
  logic              tx_wr_en_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              overflow_q;
  logic              push, pop;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign wr_ready = ~full;
  assign level    = level_q;
  assign tx_wr_en = tx_wr_en_q;
  assign tx_data  = tx_data_q;
  assign tx_busy  = (state_q != StIdle);
  assign overflow = overflow_q;
  assign tx_err   = tx_err_q;

  // Acceptance depends only on the current level, so a same-cycle pop never frees room for a push.
  assign push = wr_valid & ~full;

  // Sequencer next state: launch from idle, arm the watchdog in start, wait for done or timeout.
  always_comb begin
    state_d  = state_q;
    wdog_d   = wdog_q;
    tx_err_d = tx_err_q;
    pop      = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (tx_done) begin
          state_d = StIdle;
        end else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
          // The byte is treated as sent; it is not retried.
          tx_err_d = 1'b1;
          state_d  = StIdle;
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Storage array; contents are not reset, pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers, level, launch register, sticky flags and sequencer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      wdog_q     <= '0;
      tx_err_q   <= 1'b0;
      tx_wr_en_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      tx_err_q   <= tx_err_d;
      tx_wr_en_q <= pop;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
        tx_data_q <= mem[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      // A dropped push wins over a same-cycle clear.
      if (wr_valid && full) begin
        overflow_q <= 1'b1;
      end else if (clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based reference model predicts launches and
// flags; a scoreboard queue carries predicted launch bytes to a monitor that compares them.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 64;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              tx_wr_en;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done;
  logic              tx_busy;
  logic [ADDR_W:0]   level;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              clr_ovf;
  logic              tx_err;

  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_valid(wr_valid),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .tx_wr_en(tx_wr_en),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .tx_busy (tx_busy),
    .level   (level),
    .full    (full),
    .empty   (empty),
    .overflow(overflow),
    .clr_ovf (clr_ovf),
    .tx_err  (tx_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stored bytes as a queue, sequencer as "engaged since N edges".
  bit              m_live = 0;
  bit              m_eng  = 0;
  int              m_since = 0;
  bit [DATA_W-1:0] m_txd = '0;
  bit              m_ovf = 0;
  bit              m_err = 0;
  bit              m_pulse = 0;
  int              lvl_before = 0;
  bit [DATA_W-1:0] m_q[$];
  bit [DATA_W-1:0] exp_q[$];
  int              n_launch = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_live  = 1;
      m_q.delete();
      exp_q.delete();
      m_eng   = 0;
      m_since = 0;
      m_txd   = '0;
      m_ovf   = 0;
      m_err   = 0;
      m_pulse = 0;
    end else if (m_live) begin
      lvl_before = m_q.size();
      m_pulse    = 0;
      if (!m_eng) begin
        if (lvl_before > 0) begin
          m_txd = m_q.pop_front();
          exp_q.push_back(m_txd);
          m_pulse = 1;
          m_eng   = 1;
          m_since = 0;
        end
      end else begin
        // Edge 1 after launch ignores done; done counts from edge 2; give up after TIMEOUT waits.
        m_since++;
        if (m_since >= 2 && tx_done) begin
          m_eng = 0;
        end else if (m_since == TIMEOUT + 1) begin
          m_eng = 0;
          m_err = 1;
        end
      end
      if (wr_valid && lvl_before < DEPTH) m_q.push_back(wr_data);
      if (wr_valid && lvl_before == DEPTH) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  end

  // Monitor: scoreboard pop on every launch, plus per-cycle flag comparison.
  always @(negedge clk) begin
    if (m_live) begin
      chk("tx_wr_en", tx_wr_en, m_pulse);
      if (tx_wr_en) begin
        n_launch++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL launch_unexpected: got data %0h expected no launch at %0t", tx_data,
                   $time);
        end else begin
          chk("launch_data", tx_data, exp_q.pop_front());
        end
      end
      chk("tx_data_hold", tx_data, m_txd);
      chk("level", level, m_q.size());
      chk("full", full, m_q.size() == DEPTH);
      chk("empty", empty, m_q.size() == 0);
      chk("wr_ready", wr_ready, m_q.size() != DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("tx_err", tx_err, m_err);
      chk("tx_busy", tx_busy, m_eng);
    end
  end

  // Transmitter stand-in: done_delay -1 stalls, 0 random 1..10 cycles, >0 fixed cycles.
  int   done_delay = -1;
  bit   noise_en   = 0;
  int   done_cnt   = 0;
  logic auto_done  = 1'b0;
  logic force_done = 1'b0;
  assign tx_done = auto_done | force_done;

  always @(negedge clk) begin
    auto_done = 1'b0;
    if (rst) begin
      done_cnt = 0;
    end else begin
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) auto_done = 1'b1;
      end
      if (tx_wr_en) begin
        if (done_delay < 0) done_cnt = 0;
        else if (done_delay == 0) done_cnt = int'($urandom_range(1, 10));
        else done_cnt = done_delay;
      end
      if (noise_en && $urandom_range(0, 30) == 0) auto_done = 1'b1;
    end
  end

  task automatic push(input logic [DATA_W-1:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_done();
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int peak);
    int n;
    n    = 0;
    peak = int'(level);
    while (!(empty && !tx_busy && !tx_wr_en) && n < budget) begin
      @(negedge clk);
      if (int'(level) > peak) peak = int'(level);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL idle_budget: still busy after %0d cycles (level %0d)", n, level);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int peak;
    int base;
    int n;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset then idle.
    repeat (5) @(negedge clk);
    chk("reset_wr_ready", wr_ready, 1);
    chk("reset_empty", empty, 1);
    chk("reset_level", level, 0);
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_no_launch", n_launch, 0);

    // Single byte: launch after k+1, done 20 cycles after launch.
    done_delay = 20;
    push(8'hA9);
    chk("single_not_yet", tx_wr_en, 0);
    @(negedge clk);
    chk("single_launch", tx_wr_en, 1);
    chk("single_data", tx_data, 8'hA9);
    @(negedge clk);
    chk("single_one_cycle", tx_wr_en, 0);
    wait_idle(200, peak);
    chk("single_data_held", tx_data, 8'hA9);

    // Burst 01..05 back to back.
    done_delay = 3;
    base = n_launch;
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = DATA_W'(i);
      @(negedge clk);
      if (int'(level) > peak) peak = int'(level);
    end
    wr_valid = 1'b0;
    begin
      int p2;
      wait_idle(300, p2);
      if (p2 > peak) peak = p2;
    end
    chk("burst_peak_ok", (peak == 4 || peak == 5), 1);
    chk("burst_launches", n_launch - base, 5);
    chk("burst_empty", empty, 1);

    // Full and wrap with a stalled transmitter.
    done_delay = -1;
    for (int i = 0; i < 18; i++) push(DATA_W'(8'h10 + i));
    chk("full_flag", full, 1);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_level", level, DEPTH);
    chk("full_overflow", overflow, 1);
    wr_valid = 1'b1; wr_data = 8'hEE; clr_ovf = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; clr_ovf = 1'b0;
    chk("ovf_set_beats_clear", overflow, 1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);
    done_delay = 2;
    pulse_done();
    wait_idle(500, peak);
    chk("wrap_drained_queue", exp_q.size(), 0);

    // Push in the same cycle as the idle pop, with three bytes stored.
    done_delay = -1;
    for (int i = 0; i < 4; i++) push(DATA_W'(8'h30 + i));
    chk("simul_level_before", level, 3);
    pulse_done();
    done_delay = 2;
    wr_valid = 1'b1; wr_data = 8'h3F;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("simul_launch", tx_wr_en, 1);
    chk("simul_level_kept", level, 3);
    wait_idle(300, peak);

    // Watchdog expiry, then reset in the middle of the next frame.
    done_delay = -1;
    base = n_launch;
    push(8'h5A);
    push(8'hA5);
    n = 0;
    while (n_launch < base + 2 && n < TIMEOUT + 30) begin
      @(negedge clk);
      n++;
    end
    chk("wdog_next_launch", n_launch - base, 2);
    chk("wdog_tx_err", tx_err, 1);
    repeat (3) @(negedge clk);
    chk("wdog_busy_before_rst", tx_busy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx_wr_en", tx_wr_en, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_level", level, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_err", tx_err, 0);
    rst = 1'b0;
    base = n_launch;
    repeat (10) @(negedge clk);
    chk("rst_no_spurious_launch", n_launch - base, 0);

    // Randomised traffic with random frame times and stray done pulses.
    done_delay = 0;
    noise_en   = 1;
    for (int i = 0; i < 600; i++) begin
      wr_valid = ($urandom_range(0, 2) != 0);
      wr_data  = DATA_W'($urandom);
      clr_ovf  = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    wr_valid   = 1'b0;
    clr_ovf    = 1'b0;
    noise_en   = 0;
    done_delay = 3;
    wait_idle(3000, peak);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
